// File: rtl/select_unit_arbiter.sv
// Round-robin sequencer sharing one combinational select unit among NREQ requesters.
// Grants in IDLE, drives the unit for one DRIVE cycle, returns its result with a one-cycle ack.
module select_unit_arbiter #(
  parameter int              NREQ  = 4,
  parameter int              DW    = 4,
  parameter int              CW    = 6,
  parameter logic [CW-1:0]   MATCH = {CW{1'b1}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DW-1:0]       req_data,
  input  logic [NREQ*CW-1:0]       req_code,
  output logic [NREQ-1:0]          req_ack,
  output logic [DW-1:0]            rsp_data,
  output logic [DW-1:0]            dp_a,
  output logic [CW-1:0]            dp_c,
  input  logic [DW-1:0]            dp_b,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  input  logic                     clr_cnt,
  output logic [7:0]               match_cnt
);
  localparam int GW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, DRIVE, ACK} state_t;
  state_t state, state_nxt;

  logic [NREQ-1:0][DW-1:0] rdata;
  logic [NREQ-1:0][CW-1:0] rcode;
  logic [GW-1:0]           last_grant, winner, idx;
  logic                    found;

  assign rdata = req_data;
  assign rcode = req_code;

  // Search starts one past the last grant; GW-bit addition wraps modulo NREQ.
  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = last_grant + GW'(k);
      if (!found && req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid) state_nxt = DRIVE;
      DRIVE:   state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != IDLE);
    req_ack = (state == ACK) ? (NREQ'(1) << grant_id) : '0;
  end

  // Request fields are latched at grant so requesters may change them mid-flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GW'(NREQ - 1);
      grant_id   <= '0;
      dp_a       <= '0;
      dp_c       <= '0;
      rsp_data   <= '0;
    end else begin
      if (state == IDLE && |req_valid) begin
        last_grant <= winner;
        grant_id   <= winner;
        dp_a       <= rdata[winner];
        dp_c       <= rcode[winner];
      end
      if (state == DRIVE) rsp_data <= dp_b;
    end
  end

  // Clear takes priority over a same-edge increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      match_cnt <= '0;
    else if (clr_cnt)
      match_cnt <= '0;
    else if (state == DRIVE && dp_c == MATCH && match_cnt != 8'hFF)
      match_cnt <= match_cnt + 8'd1;
  end
endmodule

// File: tb/tb_select_unit_arbiter.sv
// Bench for select_unit_arbiter: transaction-level round-robin/counter model, randomized traffic.
module tb_select_unit_arbiter;
  localparam int NREQ = 4, DW = 4, CW = 6;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ*CW-1:0]   req_code;
  logic [NREQ-1:0]      req_ack;
  logic [DW-1:0]        rsp_data, dp_a, dp_b;
  logic [CW-1:0]        dp_c;
  logic [1:0]           grant_id;
  logic                 busy, clr_cnt;
  logic [7:0]           match_cnt;

  logic [DW-1:0] d [NREQ];
  logic [CW-1:0] c [NREQ];

  int checks = 0, errors = 0;
  int cyc = 0;
  int m_last, m_cnt, last_ack_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb begin
    req_data = '0;
    req_code = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*DW +: DW] = d[i];
      req_code[i*CW +: CW] = c[i];
    end
  end

  // The shared select unit itself lives outside the arbiter.
  assign dp_b = (dp_c == 6'h3F) ? dp_a : 4'h5;

  select_unit_arbiter #(.NREQ(NREQ), .DW(DW), .CW(CW), .MATCH(6'h3F)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_code(req_code),
    .req_ack(req_ack), .rsp_data(rsp_data), .dp_a(dp_a), .dp_c(dp_c), .dp_b(dp_b),
    .grant_id(grant_id), .busy(busy), .clr_cnt(clr_cnt), .match_cnt(match_cnt)
  );

  function automatic int rr_pick(input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      int i = (m_last + k) % NREQ;
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_last = NREQ - 1;
    m_cnt  = 0;
    last_ack_cyc = cyc;
  endtask

  // One transaction: wait for IDLE, then check the DRIVE cycle and the ACK cycle.
  task automatic do_txn(input string nm, input bit perturb, input bit clr,
                        output int win, output int gap);
    int n = 0;
    logic [DW-1:0] ed, er;
    logic [CW-1:0] ec;
    while (busy !== 1'b0 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (busy !== 1'b0 || req_ack !== '0) begin
      errors++;
      $display("FAIL %s idle: busy=%b ack=%b, expected busy=0 ack=0000", nm, busy, req_ack);
    end
    win = rr_pick(req_valid);
    ed  = d[win];
    ec  = c[win];
    er  = (ec == 6'h3F) ? ed : 4'h5;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || req_ack !== '0 || dp_a !== ed || dp_c !== ec || grant_id !== 2'(win)) begin
      errors++;
      $display("FAIL %s drive: busy=%b ack=%b dp_a=%h dp_c=%h gid=%0d, expected busy=1 ack=0000 dp_a=%h dp_c=%h gid=%0d",
               nm, busy, req_ack, dp_a, dp_c, grant_id, ed, ec, win);
    end
    if (perturb) begin
      req_valid[win] = 1'b0;
      d[win] = ~ed;
    end
    if (clr) clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    m_last = win;
    if (clr) m_cnt = 0;
    else if (ec == 6'h3F && m_cnt < 255) m_cnt++;
    gap = cyc - last_ack_cyc;
    last_ack_cyc = cyc;
    checks++;
    if (req_ack !== (4'b0001 << win) || rsp_data !== er || grant_id !== 2'(win) || match_cnt !== 8'(m_cnt)) begin
      errors++;
      $display("FAIL %s ack: ack=%b rsp=%h gid=%0d cnt=%0d, expected ack=%b rsp=%h gid=%0d cnt=%0d",
               nm, req_ack, rsp_data, grant_id, match_cnt, 4'b0001 << win, er, win, m_cnt);
    end
  endtask

  task automatic test_reset();
    int w, g;
    #1;
    checks++;
    if (req_ack !== '0 || busy !== 1'b0 || grant_id !== '0 || dp_a !== '0 || dp_c !== '0 ||
        rsp_data !== '0 || match_cnt !== '0) begin
      errors++;
      $display("FAIL reset_init: ack=%b busy=%b gid=%0d dp_a=%h dp_c=%h rsp=%h cnt=%0d, expected all zero",
               req_ack, busy, grant_id, dp_a, dp_c, rsp_data, match_cnt);
    end
    @(negedge clk); rst = 1'b0;
    // Abort a matching transaction while it is in DRIVE.
    d[0] = 4'h3; c[0] = 6'h3F; req_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_drive: busy=%b, expected 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (req_ack !== '0 || busy !== 1'b0 || grant_id !== '0 || dp_a !== '0 || dp_c !== '0 ||
        rsp_data !== '0 || match_cnt !== '0) begin
      errors++;
      $display("FAIL reset_async: ack=%b busy=%b gid=%0d dp_a=%h dp_c=%h rsp=%h cnt=%0d, expected all zero",
               req_ack, busy, grant_id, dp_a, dp_c, rsp_data, match_cnt);
    end
    @(negedge clk);
    checks++;
    if (req_ack !== '0) begin
      errors++;
      $display("FAIL reset_no_ack: ack=%b, expected 0000", req_ack);
    end
    for (int i = 0; i < NREQ; i++) begin d[i] = 4'($urandom); c[i] = 6'h00; end
    req_valid = 4'b1111;
    rst = 1'b0;
    model_reset();
    do_txn("reset_first", 1'b0, 1'b0, w, g);
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL reset_first_grant: grant=%0d, expected 0", w);
    end
  endtask

  task automatic test_matching();
    int w, g;
    req_valid = 4'b0001; d[0] = 4'hA; c[0] = 6'h3F;
    do_txn("matching", 1'b0, 1'b0, w, g);
    checks++;
    if (match_cnt !== 8'd1 || rsp_data !== 4'hA) begin
      errors++;
      $display("FAIL matching_cnt: cnt=%0d rsp=%h, expected cnt=1 rsp=a", match_cnt, rsp_data);
    end
    req_valid = '0;
  endtask

  task automatic test_nonmatching();
    int w, g;
    req_valid = 4'b0010; d[1] = 4'hC; c[1] = 6'h3E;
    do_txn("nonmatching", 1'b0, 1'b0, w, g);
    checks++;
    if (match_cnt !== 8'd1 || rsp_data !== 4'h5 || w != 1) begin
      errors++;
      $display("FAIL nonmatching_res: cnt=%0d rsp=%h grant=%0d, expected cnt=1 rsp=5 grant=1", match_cnt, rsp_data, w);
    end
    req_valid = '0;
  endtask

  task automatic test_fairness();
    int w, g;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    for (int i = 0; i < NREQ; i++) begin d[i] = 4'($urandom); c[i] = ($urandom_range(0, 1) != 0) ? 6'h3F : 6'h11; end
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      do_txn("fairness", 1'b0, 1'b0, w, g);
      checks++;
      if (w != k % NREQ || (k > 0 && g != 3)) begin
        errors++;
        $display("FAIL fairness_order: txn=%0d grant=%0d gap=%0d, expected grant=%0d gap=3", k, w, g, k % NREQ);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_stability();
    int w, g;
    req_valid = 4'b0001; d[0] = 4'h7; c[0] = 6'h3F;
    do_txn("stability", 1'b1, 1'b0, w, g);
    checks++;
    if (rsp_data !== 4'h7 || req_ack !== 4'b0001) begin
      errors++;
      $display("FAIL stability_latched: rsp=%h ack=%b, expected rsp=7 ack=0001", rsp_data, req_ack);
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    int w, g;
    for (int k = 0; k < 40; k++) begin
      req_valid = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        d[i] = 4'($urandom);
        c[i] = ($urandom_range(0, 1) != 0) ? 6'h3F : 6'($urandom);
      end
      do_txn("random", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0), w, g);
    end
    req_valid = '0;
  endtask

  task automatic test_counter();
    int w, g;
    req_valid = 4'b0001; d[0] = 4'h9; c[0] = 6'h3F;
    for (int k = 0; k < 300; k++) do_txn("counter", 1'b0, 1'b0, w, g);
    checks++;
    if (match_cnt !== 8'd255) begin
      errors++;
      $display("FAIL counter_saturate: cnt=%0d, expected 255", match_cnt);
    end
    do_txn("counter_clr", 1'b0, 1'b1, w, g);
    checks++;
    if (match_cnt !== 8'd0) begin
      errors++;
      $display("FAIL counter_clear_wins: cnt=%0d, expected 0", match_cnt);
    end
    req_valid = '0;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; clr_cnt = 1'b0;
    for (int i = 0; i < NREQ; i++) begin d[i] = '0; c[i] = '0; end
    test_reset();
    test_matching();
    test_nonmatching();
    test_fairness();
    test_stability();
    test_random();
    test_counter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
